// File: rtl/arith_encoder_stream_checker_pkg.sv
// Shared types for the arithmetic encoder stream checker.
//   chk_state_e  : checker run state
//   tail_entry_t : one delay-line entry {valid, range, low}. Fields are sized to
//                  ENTRY_MAX_W and zero-extended, so one type serves every
//                  RANGE_WIDTH/LOW_WIDTH build (both must be <= ENTRY_MAX_W).
//   sat_inc      : increment that sticks at all-ones for a given counter width
package arith_chk_pkg;

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, HALT} chk_state_e;

    localparam int ENTRY_MAX_W = 64;

    typedef struct packed {
        logic                   valid;
        logic [ENTRY_MAX_W-1:0] range;
        logic [ENTRY_MAX_W-1:0] low;
    } tail_entry_t;

    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] top;
        top = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= top) ? top : v + 64'd1;
    endfunction

endpackage

// File: rtl/arith_encoder_stream_checker_if.sv
// Stream bundle between the expected-value source / encoder and the checker.
//   exp_valid, exp_last, exp_range, exp_low : expected pair, aligned to symbol input
//   dut_range, dut_low                      : live encoder RANGE/LOW outputs
// master = driving side, slave = checker side.
interface arith_encoder_stream_checker_if #(
    parameter int RANGE_WIDTH = 16,
    parameter int LOW_WIDTH   = 24
);
    logic                   exp_valid;
    logic                   exp_last;
    logic [RANGE_WIDTH-1:0] exp_range;
    logic [LOW_WIDTH-1:0]   exp_low;
    logic [RANGE_WIDTH-1:0] dut_range;
    logic [LOW_WIDTH-1:0]   dut_low;

    modport master (output exp_valid, exp_last, exp_range, exp_low, dut_range, dut_low);
    modport slave  (input  exp_valid, exp_last, exp_range, exp_low, dut_range, dut_low);
endinterface

// File: rtl/arith_encoder_stream_checker_delay_line.sv
// LATENCY-deep shift register of tail entries, advancing every cycle.
//   general_clk, reset : clock, synchronous active-high reset (clears valid bits)
//   flush              : clear every valid bit on this edge, incoming entry included
//   push               : entry entering stage 0
//   tail               : oldest entry, pushed exactly LATENCY cycles earlier
module arith_chk_delay_line
    import arith_chk_pkg::*;
#(
    parameter int LATENCY = 3
) (
    input  logic        general_clk,
    input  logic        reset,
    input  logic        flush,
    input  tail_entry_t push,
    output tail_entry_t tail
);

    tail_entry_t stage_q [LATENCY];
    tail_entry_t stage_d [LATENCY];

    always_comb begin
        stage_d[0] = push;
        for (int i = 1; i < LATENCY; i++) stage_d[i] = stage_q[i-1];
        if (flush) begin
            for (int i = 0; i < LATENCY; i++) stage_d[i].valid = 1'b0;
        end
    end

    // Only valid bits need a reset value; payload is ignored while invalid.
    always_ff @(posedge general_clk) begin
        for (int i = 0; i < LATENCY; i++) begin
            if (reset) stage_q[i].valid <= 1'b0;
            else       stage_q[i]       <= stage_d[i];
        end
    end

    assign tail = stage_q[LATENCY-1];

endmodule

// File: rtl/arith_encoder_stream_checker.sv
// Self-checker for the arithmetic encoder: delays each expected range/low pair by
// LATENCY cycles and compares it with the live encoder outputs, keeping
// saturating per-channel match/miss counters and optionally halting on a miss.
//   general_clk, reset   : clock, synchronous active-high reset
//   start, stop_on_miss  : begin a run (IDLE/DONE/HALT only); halt-on-miss mode
//   s_if                 : expected stream + encoder outputs (slave side)
//   busy, done, halted   : RUN|DRAIN, DONE, HALT
//   match_*/miss_*       : per-channel counters; sample_idx = compares so far
//   first_miss_*         : index and values of the first miss of the run
// Build option: define ARITH_CHK_CAPTURE_EN to build the first_miss_* capture
// registers; otherwise those outputs are tied to 0.
module arith_encoder_stream_checker
    import arith_chk_pkg::*;
#(
    parameter int RANGE_WIDTH = 16,
    parameter int LOW_WIDTH   = 24,
    parameter int LATENCY     = 3,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   general_clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop_on_miss,
    arith_encoder_stream_checker_if.slave s_if,
    output logic                   busy,
    output logic                   done,
    output logic                   halted,
    output logic [CNT_WIDTH-1:0]   match_range,
    output logic [CNT_WIDTH-1:0]   miss_range,
    output logic [CNT_WIDTH-1:0]   match_low,
    output logic [CNT_WIDTH-1:0]   miss_low,
    output logic [CNT_WIDTH-1:0]   sample_idx,
    output logic [CNT_WIDTH-1:0]   first_miss_idx,
    output logic [RANGE_WIDTH-1:0] first_miss_exp_range,
    output logic [RANGE_WIDTH-1:0] first_miss_dut_range,
    output logic [LOW_WIDTH-1:0]   first_miss_exp_low,
    output logic [LOW_WIDTH-1:0]   first_miss_dut_low
);

    function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] v);
        return CNT_WIDTH'(sat_inc(64'(v), CNT_WIDTH));
    endfunction

    chk_state_e state_q, state_d;
    logic [3:0] drain_cnt_q, drain_cnt_d;
    logic       som_q, som_d;
    logic       push_en, clr, flush;
    logic       cmp_vld, rng_miss, low_miss, any_miss, halt_now;
    tail_entry_t push_e, tail_e;

    logic [CNT_WIDTH-1:0] match_range_q, match_range_d, miss_range_q, miss_range_d;
    logic [CNT_WIDTH-1:0] match_low_q, match_low_d, miss_low_q, miss_low_d;
    logic [CNT_WIDTH-1:0] sample_idx_q, sample_idx_d;

    // ---------------- delay line ----------------
    always_comb begin
        push_e       = '0;
        push_e.valid = push_en;
        push_e.range = ENTRY_MAX_W'(s_if.exp_range);
        push_e.low   = ENTRY_MAX_W'(s_if.exp_low);
    end

    arith_chk_delay_line #(.LATENCY(LATENCY)) u_delay (
        .general_clk (general_clk),
        .reset       (reset),
        .flush       (flush),
        .push        (push_e),
        .tail        (tail_e)
    );

    // ---------------- compare ----------------
    assign cmp_vld  = tail_e.valid && busy;
    assign rng_miss = cmp_vld && (tail_e.range != ENTRY_MAX_W'(s_if.dut_range));
    assign low_miss = cmp_vld && (tail_e.low   != ENTRY_MAX_W'(s_if.dut_low));
    assign any_miss = rng_miss || low_miss;
    assign halt_now = any_miss && som_q;

    // ---------------- FSM ----------------
    always_ff @(posedge general_clk) begin
        if (reset) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            som_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            som_q       <= som_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        som_d       = som_q;
        case (state_q)
            IDLE, DONE, HALT: begin
                if (start) begin
                    state_d = RUN;
                    som_d   = stop_on_miss;
                end
            end
            RUN: begin
                if (halt_now) state_d = HALT;
                else if (s_if.exp_valid && s_if.exp_last) begin
                    state_d     = DRAIN;
                    drain_cnt_d = 4'(LATENCY);
                end
            end
            DRAIN: begin
                // Leave as the count hits zero: that is the cycle the last
                // entry is compared, so DONE appears with the final counters.
                if (halt_now) state_d = HALT;
                else begin
                    drain_cnt_d = drain_cnt_q - 4'd1;
                    if (drain_cnt_q == 4'd1) state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q == RUN) || (state_q == DRAIN);
        done    = (state_q == DONE);
        halted  = (state_q == HALT);
        push_en = s_if.exp_valid && (state_q == RUN);
        clr     = start && !busy;
        flush   = (state_d == HALT) && (state_q != HALT);
    end

    // ---------------- counters ----------------
    always_comb begin
        match_range_d = match_range_q;
        miss_range_d  = miss_range_q;
        match_low_d   = match_low_q;
        miss_low_d    = miss_low_q;
        sample_idx_d  = sample_idx_q;
        if (clr) begin
            match_range_d = '0;
            miss_range_d  = '0;
            match_low_d   = '0;
            miss_low_d    = '0;
            sample_idx_d  = '0;
        end else if (cmp_vld) begin
            if (rng_miss) miss_range_d  = cnt_inc(miss_range_q);
            else          match_range_d = cnt_inc(match_range_q);
            if (low_miss) miss_low_d    = cnt_inc(miss_low_q);
            else          match_low_d   = cnt_inc(match_low_q);
            sample_idx_d = cnt_inc(sample_idx_q);
        end
    end

    always_ff @(posedge general_clk) begin
        if (reset) begin
            match_range_q <= '0;
            miss_range_q  <= '0;
            match_low_q   <= '0;
            miss_low_q    <= '0;
            sample_idx_q  <= '0;
        end else begin
            match_range_q <= match_range_d;
            miss_range_q  <= miss_range_d;
            match_low_q   <= match_low_d;
            miss_low_q    <= miss_low_d;
            sample_idx_q  <= sample_idx_d;
        end
    end

    assign match_range = match_range_q;
    assign miss_range  = miss_range_q;
    assign match_low   = match_low_q;
    assign miss_low    = miss_low_q;
    assign sample_idx  = sample_idx_q;

    // ---------------- first-miss capture ----------------
`ifdef ARITH_CHK_CAPTURE_EN
    logic [CNT_WIDTH-1:0]   first_miss_idx_q, first_miss_idx_d;
    logic [RANGE_WIDTH-1:0] first_miss_exp_range_q, first_miss_exp_range_d;
    logic [RANGE_WIDTH-1:0] first_miss_dut_range_q, first_miss_dut_range_d;
    logic [LOW_WIDTH-1:0]   first_miss_exp_low_q, first_miss_exp_low_d;
    logic [LOW_WIDTH-1:0]   first_miss_dut_low_q, first_miss_dut_low_d;
    logic                   first_miss;

    // Miss counters are cleared at start and saturate rather than wrap, so both
    // being zero means no miss has happened yet in this run.
    assign first_miss = any_miss && (miss_range_q == '0) && (miss_low_q == '0);

    always_comb begin
        first_miss_idx_d       = first_miss_idx_q;
        first_miss_exp_range_d = first_miss_exp_range_q;
        first_miss_dut_range_d = first_miss_dut_range_q;
        first_miss_exp_low_d   = first_miss_exp_low_q;
        first_miss_dut_low_d   = first_miss_dut_low_q;
        if (clr) begin
            first_miss_idx_d       = '0;
            first_miss_exp_range_d = '0;
            first_miss_dut_range_d = '0;
            first_miss_exp_low_d   = '0;
            first_miss_dut_low_d   = '0;
        end else if (first_miss) begin
            first_miss_idx_d       = sample_idx_q;
            first_miss_exp_range_d = tail_e.range[RANGE_WIDTH-1:0];
            first_miss_dut_range_d = s_if.dut_range;
            first_miss_exp_low_d   = tail_e.low[LOW_WIDTH-1:0];
            first_miss_dut_low_d   = s_if.dut_low;
        end
    end

    always_ff @(posedge general_clk) begin
        if (reset) begin
            first_miss_idx_q       <= '0;
            first_miss_exp_range_q <= '0;
            first_miss_dut_range_q <= '0;
            first_miss_exp_low_q   <= '0;
            first_miss_dut_low_q   <= '0;
        end else begin
            first_miss_idx_q       <= first_miss_idx_d;
            first_miss_exp_range_q <= first_miss_exp_range_d;
            first_miss_dut_range_q <= first_miss_dut_range_d;
            first_miss_exp_low_q   <= first_miss_exp_low_d;
            first_miss_dut_low_q   <= first_miss_dut_low_d;
        end
    end

    assign first_miss_idx       = first_miss_idx_q;
    assign first_miss_exp_range = first_miss_exp_range_q;
    assign first_miss_dut_range = first_miss_dut_range_q;
    assign first_miss_exp_low   = first_miss_exp_low_q;
    assign first_miss_dut_low   = first_miss_dut_low_q;
`else
    assign first_miss_idx       = '0;
    assign first_miss_exp_range = '0;
    assign first_miss_dut_range = '0;
    assign first_miss_exp_low   = '0;
    assign first_miss_dut_low   = '0;
`endif

endmodule
